// File: rtl/hitmark_pkg.sv
// Shared types and constants for the hitmark sprite path.
package hitmark_pkg;

    localparam int unsigned H_SIZE         = 16;
    localparam int unsigned V_SIZE         = 16;
    localparam int unsigned PIX_PER_SPRITE = H_SIZE * V_SIZE;
    localparam int unsigned CODE_W         = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WR_LO,
        WR_HI,
        DONE
    } loader_state_t;

    // One stream byte carries two palette codes; the low nibble is drawn first.
    typedef struct packed {
        logic [CODE_W-1:0] hi;
        logic [CODE_W-1:0] lo;
    } pix_pair_t;

endpackage

// File: rtl/hitmark_loader.sv
// Byte-stream loader for the hitmark sprite RAM: unpacks two palette codes
// per byte and writes them sequentially into one sprite slot or the whole RAM.
module hitmark_loader
    import hitmark_pkg::*;
#(
    parameter int unsigned ADDR  = 10,
    parameter int unsigned PIX_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_all,
    input  logic [ADDR-9:0]   slot,
    input  logic              gate_en,
    input  logic              vblank,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              we,
    output logic [ADDR-1:0]   addr_w,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              busy,
    output logic              done
);

    loader_state_t   state_q, state_d;
    logic [ADDR-1:0] cnt_q, cnt_d;
    logic [ADDR-1:0] end_q, end_d;
    pix_pair_t       pair_q, pair_d;
    logic            we_d;
    logic [ADDR-1:0] addr_d;
    logic [PIX_W-1:0] pix_d;
    logic            busy_d;
    logic            done_d;
    pix_pair_t       in_pair;

    assign in_pair = pix_pair_t'(s_data);

    // Byte acceptance is only offered while waiting for data, optionally held off outside vblank.
    assign s_ready = (state_q == FETCH) && (!gate_en || vblank);

    // Next-state and next-output logic; the counter always holds the address of the next write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        end_d   = end_q;
        pair_d  = pair_q;
        we_d    = 1'b0;
        addr_d  = addr_w;
        pix_d   = pixel_out;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = load_all ? '0 : {slot, 8'h00};
                    end_d   = load_all ? '1 : {slot, 8'hFF};
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy_d = 1'b1;
                if (s_valid && s_ready) begin
                    pair_d  = in_pair;
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    pix_d   = PIX_W'(in_pair.lo);
                    cnt_d   = cnt_q + ADDR'(1);
                    state_d = WR_LO;
                end
            end
            WR_LO: begin
                busy_d  = 1'b1;
                we_d    = 1'b1;
                addr_d  = cnt_q;
                pix_d   = PIX_W'(pair_q.hi);
                state_d = WR_HI;
            end
            WR_HI: begin
                // Equality end test lets a full load stop at the top address without wrapping.
                if (cnt_q == end_q) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                    cnt_d   = cnt_q + ADDR'(1);
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            end_q     <= '0;
            pair_q    <= '0;
            we        <= 1'b0;
            addr_w    <= '0;
            pixel_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            end_q     <= end_d;
            pair_q    <= pair_d;
            we        <= we_d;
            addr_w    <= addr_d;
            pixel_out <= pix_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_hitmark_loader.sv
// Bench for hitmark_loader: a cycle-level reference model of the byte-to-write
// stream plus directed scenarios with hand-computed checkpoints.
module tb_hitmark_loader;

    localparam int ADDR = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            load_all;
    logic [1:0]      slot;
    logic            gate_en;
    logic            vblank;
    logic [7:0]      s_data;
    logic            s_valid;
    logic            s_ready;
    logic            we;
    logic [ADDR-1:0] addr_w;
    logic [3:0]      pixel_out;
    logic            busy;
    logic            done;

    hitmark_loader #(.ADDR(ADDR), .PIX_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .load_all(load_all), .slot(slot),
        .gate_en(gate_en), .vblank(vblank), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .we(we), .addr_w(addr_w), .pixel_out(pixel_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a load in progress, and the writes still owed for accepted bytes.
    bit        m_run = 0, m_done_now = 0;
    int        m_next = 0, m_end = 0;
    bit        p1_v = 0, p2_v = 0;
    int        p1_addr = 0, p2_addr = 0;
    logic [7:0] p1_byte = 0;
    logic [3:0] p2_pix = 0;

    int ram_exp [1024];
    int ram_dut [1024];
    int wr_log [$];
    int done_cnt = 0;
    int cyc = 0, last_wr_cyc = 0, done_cyc = 0;

    // Per-cycle compare of every DUT output against the model, then model advance.
    initial begin
        @(posedge clk);
        forever begin
            bit   exp_we, exp_ready, nd, nstart, hs;
            int   exp_addr;
            logic [3:0] exp_pix;
            @(negedge clk);
            cyc++;
            exp_we = p1_v || p2_v;
            chk("we", 32'(we), 32'(exp_we));
            if (exp_we) begin
                exp_addr = p1_v ? p1_addr : p2_addr;
                exp_pix  = p1_v ? p1_byte[3:0] : p2_pix;
                chk("addr_w", 32'(addr_w), 32'(exp_addr));
                chk("pixel_out", 32'(pixel_out), 32'(exp_pix));
                ram_exp[exp_addr] = int'(exp_pix);
            end
            exp_ready = m_run && !p1_v && !p2_v && (!gate_en || vblank);
            chk("s_ready", 32'(s_ready), 32'(exp_ready));
            chk("busy", 32'(busy), 32'(m_run));
            chk("done", 32'(done), 32'(m_done_now));
            if (we === 1'b1) begin
                ram_dut[addr_w] = int'(pixel_out);
                wr_log.push_back(int'(addr_w));
                last_wr_cyc = cyc;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (reset) begin
                m_run = 0; m_done_now = 0; p1_v = 0; p2_v = 0;
            end else begin
                nd     = p2_v && (p2_addr == m_end);
                nstart = !m_run && !m_done_now && start;
                hs     = s_valid && exp_ready;
                p2_v    = p1_v;
                p2_addr = p1_addr + 1;
                p2_pix  = p1_byte[7:4];
                p1_v    = hs;
                if (hs) begin
                    p1_addr = m_next;
                    p1_byte = s_data;
                    m_next += 2;
                end
                m_done_now = nd;
                if (nd) m_run = 0;
                if (nstart) begin
                    m_run  = 1;
                    m_next = load_all ? 0 : int'(slot) * 256;
                    m_end  = load_all ? 1023 : int'(slot) * 256 + 255;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int sl, input bit all);
        start = 1'b1; slot = 2'(sl); load_all = all;
        tick();
        start = 1'b0;
    endtask

    // Offer one byte after an idle gap; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = b;
        k = 0;
        forever begin
            @(negedge clk);
            if (s_ready === 1'b1) break;
            k++;
            if (k > 200) begin
                chk("handshake_timeout", 0, 1);
                s_valid = 1'b0;
                return;
            end
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 50) begin
            tick();
            k++;
        end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
        repeat (3) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, bad, n0;
        reset = 1'b1; start = 1'b0; load_all = 1'b0; slot = 2'd0;
        gate_en = 1'b0; vblank = 1'b0; s_data = 8'h00; s_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_addr_w", 32'(addr_w), 0);
        chk("rst_pixel_out", 32'(pixel_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        tick();
        reset = 1'b0;
        tick();

        // Idle with data offered: nothing consumed.
        s_valid = 1'b1; s_data = 8'h77;
        @(negedge clk);
        chk("idle_s_ready", 32'(s_ready), 0);
        tick();
        s_valid = 1'b0;

        // 1: slot 2, bytes 0x21, 0x43, ...
        d0 = done_cnt; wr_log.delete();
        do_start(2, 0);
        for (int k = 0; k < 128; k++) send_byte({4'(2 * k + 2), 4'(2 * k + 1)}, 0);
        wait_done(d0);
        chk("t1_we_count", 32'(wr_log.size()), 256);
        chk("t1_first_addr", 32'(wr_log[0]), 32'h200);
        chk("t1_last_addr", 32'(wr_log[255]), 32'h2FF);
        chk("t1_done_pulses", 32'(done_cnt - d0), 1);
        chk("t1_ram200", 32'(ram_dut[32'h200]), 1);
        chk("t1_ram201", 32'(ram_dut[32'h201]), 2);
        chk("t1_ram202", 32'(ram_dut[32'h202]), 3);
        chk("t1_ram203", 32'(ram_dut[32'h203]), 4);
        chk("t1_ram2fe", 32'(ram_dut[32'h2FE]), 15);
        chk("t1_ram2ff", 32'(ram_dut[32'h2FF]), 0);

        // 2: whole RAM, 512 bytes
        d0 = done_cnt; wr_log.delete();
        do_start(0, 1);
        for (int k = 0; k < 512; k++) send_byte(8'(k * 7 + 3), 0);
        wait_done(d0);
        chk("t2_we_count", 32'(wr_log.size()), 1024);
        chk("t2_first_addr", 32'(wr_log[0]), 0);
        chk("t2_last_addr", 32'(wr_log[wr_log.size() - 1]), 32'h3FF);
        chk("t2_done_after_last", 32'(done_cyc), 32'(last_wr_cyc + 1));
        chk("t2_done_pulses", 32'(done_cnt - d0), 1);
        bad = 0;
        foreach (wr_log[i]) if (wr_log[i] != i) bad++;
        chk("t2_contiguous", 32'(bad), 0);

        // 3: slot 0 with random gaps, checked against the reference RAM
        d0 = done_cnt; wr_log.delete();
        do_start(0, 0);
        for (int k = 0; k < 128; k++) send_byte(8'($urandom), int'($urandom_range(0, 3)));
        wait_done(d0);
        chk("t3_we_count", 32'(wr_log.size()), 256);
        bad = 0;
        foreach (wr_log[i]) if (wr_log[i] != i) bad++;
        chk("t3_contiguous", 32'(bad), 0);
        for (int a = 0; a < 256; a++) chk("t3_ram", 32'(ram_dut[a]), 32'(ram_exp[a]));

        // 4: vblank gating
        d0 = done_cnt; wr_log.delete();
        gate_en = 1'b1; vblank = 1'b0;
        do_start(3, 0);
        s_valid = 1'b1; s_data = 8'hA5;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t4_gated_ready", 32'(s_ready), 0);
            chk("t4_gated_we", 32'(we), 0);
            tick();
        end
        vblank = 1'b1;
        send_byte(8'hA5, 0);
        vblank = 1'b0;
        tick();
        tick();
        chk("t4_writes_after_drop", 32'(wr_log.size()), 2);
        chk("t4_ram300", 32'(ram_dut[32'h300]), 5);
        chk("t4_ram301", 32'(ram_dut[32'h301]), 32'hA);
        vblank = 1'b1;
        for (int k = 1; k < 128; k++) send_byte(8'(k), 0);
        wait_done(d0);
        chk("t4_we_count", 32'(wr_log.size()), 256);
        gate_en = 1'b0; vblank = 1'b0;

        // 5: reset mid-load, then restart
        wr_log.delete();
        do_start(1, 0);
        for (int k = 0; k < 10; k++) send_byte(8'(k + 16), 0);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("t5_we_after_reset", 32'(we), 0);
        chk("t5_busy_after_reset", 32'(busy), 0);
        reset = 1'b0;
        tick();
        d0 = done_cnt; wr_log.delete();
        do_start(1, 0);
        for (int k = 0; k < 128; k++) send_byte(8'(k), 0);
        wait_done(d0);
        chk("t5_restart_first", 32'(wr_log[0]), 32'h100);
        chk("t5_we_count", 32'(wr_log.size()), 256);

        // 6: start while busy is ignored
        d0 = done_cnt; wr_log.delete();
        do_start(1, 0);
        for (int k = 0; k < 5; k++) send_byte(8'(k + 40), 0);
        start = 1'b1; slot = 2'd2; load_all = 1'b0;
        repeat (3) tick();
        start = 1'b0;
        for (int k = 5; k < 128; k++) send_byte(8'(k + 40), 0);
        wait_done(d0);
        n0 = 0;
        foreach (wr_log[i]) if (wr_log[i] < 32'h100 || wr_log[i] > 32'h1FF) n0++;
        chk("t6_outside_slot", 32'(n0), 0);
        chk("t6_we_count", 32'(wr_log.size()), 256);
        chk("t6_done_pulses", 32'(done_cnt - d0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
